serial_subtractor: RTL and testbench

//   Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock.

---
 rtl/sersub_pkg.sv | 6 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 140 ++++++++++++++
 tb/tb_serial_subtractor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sersub_pkg.sv
// Shared types for the bit-serial subtractor.
package sersub_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} sersub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// 1-bit full subtractor cell: diff = a - b - bin, borrow out when the result goes negative.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b ^ bin;
  assign borrow = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per clock.
// Defining SERSUB_OVERFLOW_EN adds a two's-complement overflow output.
module serial_subtractor
  import sersub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERSUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  sersub_state_t    state_q, state_d;
  logic [WIDTH-1:0] aSr_q, aSr_d;
  logic [WIDTH-1:0] bSr_q, bSr_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             brw_q, brw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             cellDiff, cellBorrow;
  logic [WIDTH-1:0] resNext;

  full_subtractor u_cell (
    .a      (aSr_q[0]),
    .b      (bSr_q[0]),
    .bin    (brw_q),
    .diff   (cellDiff),
    .borrow (cellBorrow)
  );

  // The newest cell bit enters at the MSB; on the last step it completes the result.
  assign resNext = {cellDiff, res_q};

`ifdef SERSUB_OVERFLOW_EN
  logic aMsb_q, aMsb_d;
  logic bMsb_q, bMsb_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    aSr_d    = aSr_q;
    bSr_d    = bSr_q;
    res_d    = res_q;
    brw_d    = brw_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
`ifdef SERSUB_OVERFLOW_EN
    aMsb_d   = aMsb_q;
    bMsb_d   = bMsb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          aSr_d   = a;
          bSr_d   = b;
          brw_d   = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERSUB_OVERFLOW_EN
          aMsb_d  = a[WIDTH-1];
          bMsb_d  = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        res_d = resNext[WIDTH-1:1];
        aSr_d = aSr_q >> 1;
        bSr_d = bSr_q >> 1;
        brw_d = cellBorrow;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = DONE;
          diff_d   = resNext;
          borrow_d = cellBorrow;
`ifdef SERSUB_OVERFLOW_EN
          ovf_d    = (aMsb_q != bMsb_q) && (cellDiff != aMsb_q);
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      aSr_q    <= '0;
      bSr_q    <= '0;
      res_q    <= '0;
      brw_q    <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
`ifdef SERSUB_OVERFLOW_EN
      aMsb_q   <= 1'b0;
      bMsb_q   <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      aSr_q    <= aSr_d;
      bSr_q    <= bSr_d;
      res_q    <= res_d;
      brw_q    <= brw_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`ifdef SERSUB_OVERFLOW_EN
      aMsb_q   <= aMsb_d;
      bMsb_q   <= bMsb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = borrow_q;
`ifdef SERSUB_OVERFLOW_EN
  assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed 8-bit vectors, multi-cycle corner
// cases, and an exhaustive sweep of a 4-bit instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n, start, start4;
  logic [7:0] a, b, diff;
  logic [3:0] a4, b4, diff4;
  logic       busy, done, borrow, busy4, done4, borrow4;
`ifdef SERSUB_OVERFLOW_EN
  logic       ovf, ovf4;
`endif

  int checkCount = 0;
  int failCount  = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
`ifdef SERSUB_OVERFLOW_EN
    .overflow   (ovf),
`endif
    .borrow_out (borrow)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start4),
    .a          (a4),
    .b          (b4),
    .busy       (busy4),
    .done       (done4),
    .diff       (diff4),
`ifdef SERSUB_OVERFLOW_EN
    .overflow   (ovf4),
`endif
    .borrow_out (borrow4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Starts one 8-bit operation and returns the number of edges after the accept
  // edge until done is seen (-1 if it never appears).
  task automatic applyStimulus(input logic [7:0] ai, input logic [7:0] bi,
                               output int latency);
    a = ai;
    b = bi;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    latency = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        latency = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int doneCount;
    int firstDone;
    int pulses[$];
    logic [4:0] exp4;
    logic       got4;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[7] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

    rst_n  = 1'b0;
    start  = 1'b0;
    start4 = 1'b0;
    a  = '0;
    b  = '0;
    a4 = '0;
    b4 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_diff", diff, 0);
    checkOutput("reset_borrow", borrow, 0);
    checkOutput("reset_busy4", busy4, 0);
    checkOutput("reset_diff4", diff4, 0);
`ifdef SERSUB_OVERFLOW_EN
    checkOutput("reset_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, 8);
      checkOutput($sformatf("vec%0d_diff", i), diff, vecs[i].diff);
      checkOutput($sformatf("vec%0d_borrow", i), borrow, vecs[i].borrow);
`ifdef SERSUB_OVERFLOW_EN
      checkOutput($sformatf("vec%0d_ovf", i), ovf, vecs[i].ovf);
`endif
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_done_drop", i), done, 0);
    end

    // Operands and start disturbed mid-operation must not affect the result in flight.
    a = 8'h05;
    b = 8'h03;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    doneCount = 0;
    firstDone = -1;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) checkOutput("mid_busy", busy, 1);
      if (n == 2) checkOutput("diff_held_during_shift", diff, 8'h80);
      if (done) begin
        doneCount++;
        if (firstDone < 0) firstDone = n;
      end
      if (n == 3) begin
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
      end
      if (n == 5) start = 1'b0;
    end
    checkOutput("disturb_done_count", doneCount, 1);
    checkOutput("disturb_done_edge", firstDone, 8);
    checkOutput("disturb_diff", diff, 8'h02);
    checkOutput("disturb_borrow", borrow, 0);

    // start held high: operations run back to back at a fixed period.
    a = 8'h10;
    b = 8'h01;
    start = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        pulses.push_back(n);
        checkOutput("held_diff", diff, 8'h0F);
      end
    end
    start = 1'b0;
    checkOutput("held_pulse_count_ok", (pulses.size() >= 4) ? 1 : 0, 1);
    for (int i = 1; i < pulses.size(); i++) begin
      checkOutput("held_period_const", pulses[i] - pulses[i-1], pulses[1] - pulses[0]);
    end
    if (pulses.size() >= 2) begin
      checkOutput("held_period_range",
                  ((pulses[1] - pulses[0]) >= 9 && (pulses[1] - pulses[0]) <= 10) ? 1 : 0, 1);
    end
    repeat (12) @(posedge clk);
    #1;

    // Reset during SHIFT aborts the operation with no done pulse.
    a = 8'h03;
    b = 8'h05;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_diff", diff, 0);
    checkOutput("abort_borrow", borrow, 0);
    rst_n = 1'b1;
    doneCount = 0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (done) doneCount++;
    end
    checkOutput("abort_no_done", doneCount, 0);
    applyStimulus(8'h03, 8'h05, lat);
    checkOutput("after_abort_latency", lat, 8);
    checkOutput("after_abort_diff", diff, 8'hFE);
    checkOutput("after_abort_borrow", borrow, 1);
    @(posedge clk);
    #1;

    // Exhaustive sweep of the 4-bit instance against unsigned subtraction.
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        a4 = 4'(ai);
        b4 = 4'(bi);
        start4 = 1'b1;
        @(posedge clk);
        #1 start4 = 1'b0;
        got4 = 1'b0;
        for (int n = 1; n <= 10; n++) begin
          @(posedge clk);
          #1;
          if (done4) begin
            got4 = 1'b1;
            break;
          end
        end
        exp4 = ({1'b0, a4} - {1'b0, b4}) & 5'h1F;
        if (!got4) checkOutput($sformatf("w4_timeout_%0h_%0h", ai, bi), 0, 1);
        else checkOutput($sformatf("w4_%0h_%0h", ai, bi), {borrow4, diff4}, exp4);
        @(posedge clk);
        #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
